// File: rtl/cla8_pkg.sv
// Shared types for the CLA8 request sequencer.
// Operand bundle, FSM state encoding and datapath width.
package cla8_pkg;

  localparam int CLA8_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } cla8_seq_state_t;

  typedef struct packed {
    logic [CLA8_W-1:0] a;
    logic [CLA8_W-1:0] b;
    logic              cin;
  } cla8_op_t;

endpackage

// File: rtl/cla8_rr_arb2.sv
// Two-input round-robin grant for the CLA8 sequencer.
// prio names the requester that wins a tie; it flips to the loser on update.
module cla8_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  logic prio;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (valid0 & ~valid1): gnt0 = 1'b1;
      (valid1 & ~valid0): gnt1 = 1'b1;
      (valid0 & valid1): begin
        gnt0 = ~prio;
        gnt1 = prio;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= gnt0;
    end
  end

endmodule

// File: rtl/cla8_req_sequencer.sv
// Arbitrates two requesters onto a shared 8-bit CLA and returns tagged sums.
// Optional CLA8_SEQ_OVF_EN adds the signed overflow output rsp_ovf.
module cla8_req_sequencer
  import cla8_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_cin,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_cin,
  output logic [7:0] cla_a,
  output logic [7:0] cla_b,
  output logic       cla_cin,
  input  logic [7:0] cla_sum,
  input  logic       cla_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_sum,
`ifdef CLA8_SEQ_OVF_EN
  output logic       rsp_ovf,
`endif
  output logic       rsp_cout
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  cla8_seq_state_t state;
  logic [CW-1:0]   cnt;
  cla8_op_t        op0;
  cla8_op_t        op1;
  cla8_op_t        win;
  cla8_op_t        cla_q;
  logic            owner;
  logic            idle;
  logic            accept;
  logic            gnt0;
  logic            gnt1;

  assign idle   = (state == IDLE);
  assign accept = idle & (req0_valid | req1_valid);

  cla8_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .update (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;

  assign op0 = '{a: req0_a, b: req0_b, cin: req0_cin};
  assign op1 = '{a: req1_a, b: req1_b, cin: req1_cin};
  assign win = gnt1 ? op1 : op0;

  assign cla_a   = cla_q.a;
  assign cla_b   = cla_q.b;
  assign cla_cin = cla_q.cin;

  // cla_q only moves on accept, so the CLA sees stable inputs until the next op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cla_q     <= '0;
      owner     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cla_q <= win;
            owner <= gnt1;
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_sum   <= cla_sum;
            rsp_cout  <= cla_cout;
            rsp_id    <= owner;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLA8_SEQ_OVF_EN
  logic settle_done;

  assign settle_done = (state == SETTLE) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (settle_done) begin
      rsp_ovf <= (cla_q.a[7] == cla_q.b[7]) &&
                 (cla_sum[7] != cla_q.a[7]);
    end
  end
`endif

endmodule
